// File: rtl/alu_sub_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_sub_result_checker
// Purpose  : Self-check stage for the ALU subtract test. It delays the golden
//            A-B by the ALU latency, compares it with Q over a fixed-length
//            run, and reports errors, the first failing index and a MISR.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sub_result_checker #(
    parameter int              WIDTH     = 16,
    parameter int              LATENCY   = 1,
    parameter int              NUM_VEC   = 256,
    parameter int              ERR_W     = 16,
    parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'(16'hB400)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      first_err_idx,
    output logic             first_err_vld,
    output logic [WIDTH-1:0] signature
);

    localparam int              c_FILL_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [15:0]     c_VEC_LAST  = 16'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_FILL_W-1:0] r_fill_cnt;
    logic [15:0]         r_vec_idx;
    logic [ERR_W-1:0]    r_err_count;
    logic [ERR_W-1:0]    w_err_nxt;
    logic [15:0]         r_first_idx;
    logic                r_first_vld;
    logic [WIDTH-1:0]    r_sig;
    logic [WIDTH-1:0]    w_sig_nxt;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [WIDTH-1:0]    w_exp;
    logic                w_accept;
    logic                w_check;
    logic                w_mismatch;

    // Golden result aligned with the ALU output; the pipe shifts every cycle
    // so it is already primed by the time FILL has elapsed.
    generate
        if (LATENCY == 0) begin : g_lat_zero
            assign w_exp = a - b;
        end else begin : g_lat_pipe
            logic [WIDTH-1:0] r_dly [LATENCY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        r_dly[i] <= '0;
                    end
                end else begin
                    r_dly[0] <= a - b;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign w_exp = r_dly[LATENCY-1];
        end
    endgenerate

    always_comb begin
        w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_check     = (r_state == S_CHECK);
        w_mismatch  = w_check && (o != w_exp);
        w_err_nxt   = r_err_count;
        if (w_mismatch && !(&r_err_count)) begin
            w_err_nxt = r_err_count + ERR_W'(1);
        end
        w_sig_nxt   = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? MISR_POLY : '0) ^ o;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = (LATENCY > 0) ? S_FILL : S_CHECK;
                end
            end
            S_FILL: begin
                if (r_fill_cnt == c_FILL_LAST) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_vec_idx == c_VEC_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill_cnt  <= '0;
            r_vec_idx   <= '0;
            r_err_count <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
            r_sig       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_FILL) || (w_state_nxt == S_CHECK);
            r_done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_fill_cnt  <= '0;
                r_vec_idx   <= '0;
                r_err_count <= '0;
                r_first_idx <= '0;
                r_first_vld <= 1'b0;
                r_sig       <= '0;
                r_pass      <= 1'b0;
            end else if (r_state == S_FILL) begin
                r_fill_cnt <= r_fill_cnt + c_FILL_W'(1);
            end else if (w_check) begin
                r_vec_idx   <= r_vec_idx + 16'd1;
                r_err_count <= w_err_nxt;
                r_sig       <= w_sig_nxt;
                if (w_mismatch && !r_first_vld) begin
                    r_first_idx <= r_vec_idx;
                    r_first_vld <= 1'b1;
                end
                // pass is decided together with the final error count
                if (r_vec_idx == c_VEC_LAST) begin
                    r_pass <= (w_err_nxt == '0);
                end
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_idx;
    assign first_err_vld = r_first_vld;
    assign signature     = r_sig;

endmodule
`default_nettype wire
